mib_link_trainer: RTL

//   Master-side MIB link controller. After PLL lock it drives the fixed 7-word training pattern on the MIB bus.
//   It waits for the remote end to report alignment, retries on timeout and gives up after a set number of retries.

---
 rtl/mib_link_trainer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mib_link_trainer.sv
// MIB link trainer: sends the 7-word training pattern after PLL lock, retries on alignment timeout, then hands the bus to user data.
// All outputs are registered; user words appear on o_mib_ad one cycle after acceptance. Nothing stalls: o_usr_ready is simply high while the link is up.
module mib_link_trainer #(
  parameter int REPEATS   = 16,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic        i_clk,
  input  logic        i_srst_n,
  input  logic        i_pll_locked,
  input  logic        i_start,
  input  logic        i_rx_aligned,
  input  logic        i_usr_valid,
  input  logic [12:0] i_usr_data,
  output logic        o_usr_ready,
  output logic [12:0] o_mib_ad,
  output logic        o_mib_train,
  output logic        o_link_up,
  output logic        o_train_fail,
  output logic [3:0]  o_retry_cnt
);
  localparam int PW = $clog2(REPEATS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PASS_LAST  = PW'(REPEATS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    RETRY_LAST = 4'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_LINK_UP, S_FAIL} state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx, idx_nxt, idx_adv;
  logic [PW-1:0]   pass, pass_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [3:0]      retry_nxt;
  logic [12:0]     ad_nxt;
  logic            train_nxt, link_nxt, ready_nxt, fail_nxt, enter_send;

  function automatic logic [12:0] pattern_word(input logic [2:0] i);
    case (i)
      3'd0:    return 13'h0AAA;
      3'd1:    return 13'h0555;
      3'd2:    return 13'h0F0F;
      3'd3:    return 13'h10F0;
      3'd4:    return 13'h0000;
      3'd5:    return 13'h1FFF;
      default: return 13'h00F5;
    endcase
  endfunction

  assign idx_adv = (idx == 3'd6) ? 3'd0 : idx + 3'd1;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    pass_nxt   = pass;
    timer_nxt  = timer;
    retry_nxt  = o_retry_cnt;
    ad_nxt     = o_mib_ad;
    train_nxt  = o_mib_train;
    link_nxt   = o_link_up;
    ready_nxt  = o_usr_ready;
    fail_nxt   = o_train_fail;
    enter_send = 1'b0;

    case (state)
      S_IDLE: begin
        enter_send = 1'b1;
        retry_nxt  = 4'd0;
      end
      S_SEND: begin
        ad_nxt    = pattern_word(idx);
        train_nxt = ~o_mib_train;
        idx_nxt   = idx_adv;
        // idx==0 with all passes counted means the last word is already on the bus
        if (idx == 3'd0 && pass == PASS_LAST) begin
          state_nxt = S_WAIT_ACK;
          timer_nxt = '0;
        end else if (idx == 3'd6) begin
          pass_nxt = pass + PW'(1);
        end
      end
      S_WAIT_ACK: begin
        ad_nxt    = pattern_word(idx);
        train_nxt = ~o_mib_train;
        idx_nxt   = idx_adv;
        timer_nxt = timer + TW'(1);
        if (i_rx_aligned) begin
          state_nxt = S_LINK_UP;
          ad_nxt    = '0;
          train_nxt = 1'b0;
          link_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end else if (timer == TIMER_LAST) begin
          if (o_retry_cnt == RETRY_LAST) begin
            state_nxt = S_FAIL;
            ad_nxt    = '0;
            train_nxt = 1'b0;
            fail_nxt  = 1'b1;
          end else begin
            retry_nxt  = o_retry_cnt + 4'd1;
            enter_send = 1'b1;
          end
        end
      end
      S_LINK_UP: begin
        ad_nxt = i_usr_valid ? i_usr_data : 13'h0000;
        if (!i_rx_aligned || i_start) begin
          retry_nxt  = 4'd0;
          enter_send = 1'b1;
        end
      end
      S_FAIL: begin
        if (i_start) begin
          retry_nxt  = 4'd0;
          enter_send = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Word 0 goes out on the entry edge, so the index register points at word 1.
    if (enter_send) begin
      state_nxt = S_SEND;
      ad_nxt    = pattern_word(3'd0);
      train_nxt = 1'b1;
      idx_nxt   = 3'd1;
      pass_nxt  = '0;
      timer_nxt = '0;
      link_nxt  = 1'b0;
      ready_nxt = 1'b0;
      fail_nxt  = 1'b0;
    end

    if (!i_pll_locked) begin
      state_nxt = S_IDLE;
      idx_nxt   = 3'd0;
      pass_nxt  = '0;
      timer_nxt = '0;
      retry_nxt = 4'd0;
      ad_nxt    = '0;
      train_nxt = 1'b0;
      link_nxt  = 1'b0;
      ready_nxt = 1'b0;
      fail_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      state        <= S_IDLE;
      idx          <= 3'd0;
      pass         <= '0;
      timer        <= '0;
      o_retry_cnt  <= 4'd0;
      o_mib_ad     <= '0;
      o_mib_train  <= 1'b0;
      o_link_up    <= 1'b0;
      o_usr_ready  <= 1'b0;
      o_train_fail <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      pass         <= pass_nxt;
      timer        <= timer_nxt;
      o_retry_cnt  <= retry_nxt;
      o_mib_ad     <= ad_nxt;
      o_mib_train  <= train_nxt;
      o_link_up    <= link_nxt;
      o_usr_ready  <= ready_nxt;
      o_train_fail <= fail_nxt;
    end
  end
endmodule
